// File: rtl/ahb_lite_ram_slave.sv
// AHB-Lite responder backed by on-chip RAM with programmable wait states and byte-lane writes.
// Define AHB_RAM_ERROR_RESP_EN to give out-of-range and misaligned transfers a two-cycle ERROR response.
module ahb_lite_ram_slave #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

`ifdef AHB_RAM_ERROR_RESP_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_WAIT = 3'd1, ST_DATA = 3'd2, ST_ERR1 = 3'd3, ST_ERR2 = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DATA = 2'd2
  } state_t;
`endif

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t                 state_r, state_s;
  logic [3:0]             wait_cnt_r, wait_cnt_s;
  logic [ADDR_BITS-1:0]   addr_r;
  logic [3:0]             be_r;
  logic                   write_r;
  logic                   hready_r;
  logic                   accept_s;
  logic [31:0]            rdata_s;
  logic [31:0]            mem_r [2**ADDR_BITS];
  logic                   unused_s;

  // Little-endian lane mask; halfword ignores HADDR[0], word ignores both offset bits.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      3'd0:    m = 4'b0001 << off;
      3'd1:    m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  assign accept_s = hready_r & HSEL & HTRANS[1];
  assign unused_s = ^{HBURST, HTRANS[0], HADDR[31:ADDR_BITS+2]};

`ifdef AHB_RAM_ERROR_RESP_EN
  logic err_s;
  logic hresp_r;

  // Address-phase error classification: out of range first, then alignment by size.
  always_comb begin
    err_s = 1'b0;
    if (|HADDR[31:ADDR_BITS+2]) begin
      err_s = 1'b1;
    end else if (HSIZE == 3'd0) begin
      err_s = 1'b0;
    end else if (HSIZE == 3'd1) begin
      err_s = HADDR[0];
    end else begin
      err_s = (HADDR[1:0] != 2'b00);
    end
  end
`endif

  // Next-state and wait-counter logic.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    case (state_r)
      ST_WAIT: begin
        if (wait_cnt_r == 4'd1) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_WAIT;
        end
        wait_cnt_s = wait_cnt_r - 4'd1;
      end
`ifdef AHB_RAM_ERROR_RESP_EN
      ST_ERR1: state_s = ST_ERR2;
`endif
      default: begin
        // IDLE, DATA and ERR2 all drive HREADY high, so each can take a new transfer.
        if (!accept_s) begin
          state_s = ST_IDLE;
`ifdef AHB_RAM_ERROR_RESP_EN
        end else if (err_s) begin
          state_s = ST_ERR1;
`endif
        end else if (WAIT_INIT != 4'd0) begin
          state_s    = ST_WAIT;
          wait_cnt_s = WAIT_INIT;
        end else begin
          state_s = ST_DATA;
        end
      end
    endcase
  end

  // State, wait counter and registered handshake outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      hready_r   <= 1'b1;
`ifdef AHB_RAM_ERROR_RESP_EN
      hresp_r    <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
`ifdef AHB_RAM_ERROR_RESP_EN
      hready_r   <= (state_s != ST_WAIT) && (state_s != ST_ERR1);
      hresp_r    <= (state_s == ST_ERR1) || (state_s == ST_ERR2);
`else
      hready_r   <= (state_s != ST_WAIT);
`endif
    end
  end

  // Address-phase capture of the accepted transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_r  <= '0;
      be_r    <= 4'b0000;
      write_r <= 1'b0;
    end else if (accept_s) begin
      addr_r  <= HADDR[ADDR_BITS+1:2];
      be_r    <= lane_mask(HSIZE, HADDR[1:0]);
      write_r <= HWRITE;
    end
  end

  // RAM byte-lane write at the edge that ends a write data phase; contents are never reset.
  always_ff @(posedge HCLK) begin
    if ((state_r == ST_DATA) && write_r) begin
      for (int i = 0; i < 4; i++) begin
        if (be_r[i]) begin
          mem_r[addr_r][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Read data only from registered state and RAM, zero outside a read data phase.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if ((state_r == ST_DATA) && !write_r) begin
      rdata_s = mem_r[addr_r];
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign HRDATA = rdata_s;
  assign HREADY = hready_r;
`ifdef AHB_RAM_ERROR_RESP_EN
  assign HRESP  = hresp_r;
`else
  assign HRESP  = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_lite_ram_slave.sv
// Directed bench for ahb_lite_ram_slave: a zero-wait instance and a three-wait instance on shared bus signals.
module tb_ahb_lite_ram_slave;

  logic        clk;
  logic        rst_n;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hwrite;
  logic        hsel0, hsel3;
  logic [31:0] hrdata0, hrdata3;
  logic        hready0, hready3;
  logic        hresp0, hresp3;

  int n_vec = 0;
  int n_err = 0;

  ahb_lite_ram_slave #(.ADDR_BITS(10), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HBURST(hburst), .HSEL(hsel0),
    .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata), .HWRITE(hwrite),
    .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0)
  );

  ahb_lite_ram_slave #(.ADDR_BITS(10), .WAIT_STATES(3)) u_dut3 (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HBURST(hburst), .HSEL(hsel3),
    .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata), .HWRITE(hwrite),
    .HRDATA(hrdata3), .HREADY(hready3), .HRESP(hresp3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int k);
    return (k == 0) ? hready0 : hready3;
  endfunction

  function automatic logic rsp(input int k);
    return (k == 0) ? hresp0 : hresp3;
  endfunction

  function automatic logic [31:0] rdat(input int k);
    return (k == 0) ? hrdata0 : hrdata3;
  endfunction

  // One non-pipelined transfer on instance k; entered and left 1 time unit after a rising edge.
  task automatic xfer(input int k, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata, output int waits,
                      output logic resp_low, output logic resp_hi);
    haddr  = addr;
    hsize  = size;
    hwrite = wr;
    htrans = 2'b10;
    hsel0  = (k == 0);
    hsel3  = (k == 3);
    @(posedge clk); #1;
    htrans   = 2'b00;
    hsel0    = 1'b0;
    hsel3    = 1'b0;
    hwdata   = wdata;
    waits    = 0;
    resp_low = 1'b0;
    while (!rdy(k) && waits < 20) begin
      resp_low = resp_low | rsp(k);
      waits++;
      @(posedge clk); #1;
    end
    rdata   = rdat(k);
    resp_hi = rsp(k);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  int          nw;
  logic        rl, rh;

  initial begin
    rst_n  = 1'b0;
    haddr  = 32'h0000_0000;
    hwdata = 32'h0000_0000;
    hburst = 3'd0;
    hsize  = 3'd2;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_hready0", {31'd0, hready0}, 32'd1);
    check_vec("rst_hresp0",  {31'd0, hresp0},  32'd0);
    check_vec("rst_hrdata0", hrdata0, 32'h0000_0000);
    check_vec("rst_hready3", {31'd0, hready3}, 32'd1);
    check_vec("rst_hresp3",  {31'd0, hresp3},  32'd0);
    check_vec("rst_hrdata3", hrdata3, 32'h0000_0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero wait states: write then read the same word, pipelined.
    haddr = 32'h0000_0010; hsize = 3'd2; hwrite = 1'b1; htrans = 2'b10; hsel0 = 1'b1;
    @(posedge clk); #1;
    hwdata = 32'hDEAD_BEEF; haddr = 32'h0000_0010; hwrite = 1'b0;
    check_vec("b2b_wr_ready", {31'd0, hready0}, 32'd1);
    check_vec("b2b_wr_rdata", hrdata0, 32'h0000_0000);
    @(posedge clk); #1;
    htrans = 2'b00; hsel0 = 1'b0; hwdata = 32'h0000_0000;
    check_vec("b2b_rd_ready", {31'd0, hready0}, 32'd1);
    check_vec("b2b_rd_data", hrdata0, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check_vec("b2b_idle_rdata", hrdata0, 32'h0000_0000);

    // Three wait states: write then single read.
    xfer(3, 1'b1, 32'h0000_0040, 3'd2, 32'hCAFE_F00D, rd, nw, rl, rh);
    check_vec("ws3_wr_waits", nw, 32'd3);
    xfer(3, 1'b0, 32'h0000_0040, 3'd2, 32'h0000_0000, rd, nw, rl, rh);
    check_vec("ws3_rd_waits", nw, 32'd3);
    check_vec("ws3_rd_resp_low", {31'd0, rl}, 32'd0);
    check_vec("ws3_rd_resp_hi", {31'd0, rh}, 32'd0);
    check_vec("ws3_rd_data", rd, 32'hCAFE_F00D);

    // Byte lanes: junk in unselected lanes must not land in RAM.
    xfer(0, 1'b1, 32'h0000_0020, 3'd2, 32'h1122_3344, rd, nw, rl, rh);
    xfer(0, 1'b1, 32'h0000_0022, 3'd0, 32'hFFAA_FFFF, rd, nw, rl, rh);
    xfer(0, 1'b1, 32'h0000_0020, 3'd1, 32'hEEEE_BBCC, rd, nw, rl, rh);
    xfer(0, 1'b0, 32'h0000_0020, 3'd2, 32'h0000_0000, rd, nw, rl, rh);
    check_vec("lanes_0x20", rd, 32'h11AA_BBCC);
    check_vec("lanes_waits", nw, 32'd0);
    xfer(0, 1'b1, 32'h0000_0030, 3'd2, 32'h0000_0000, rd, nw, rl, rh);
    xfer(0, 1'b1, 32'h0000_0032, 3'd1, 32'h7788_1234, rd, nw, rl, rh);
    xfer(0, 1'b1, 32'h0000_0031, 3'd0, 32'hABCD_56EF, rd, nw, rl, rh);
    xfer(0, 1'b0, 32'h0000_0030, 3'd2, 32'h0000_0000, rd, nw, rl, rh);
    check_vec("lanes_0x30", rd, 32'h7788_5600);

    // Out-of-range byte write to 0x1000.
    xfer(0, 1'b1, 32'h0000_0000, 3'd2, 32'h0102_0304, rd, nw, rl, rh);
    xfer(0, 1'b1, 32'h0000_1000, 3'd0, 32'h0000_0055, rd, nw, rl, rh);
`ifdef AHB_RAM_ERROR_RESP_EN
    check_vec("oor_waits", nw, 32'd1);
    check_vec("oor_resp_low", {31'd0, rl}, 32'd1);
    check_vec("oor_resp_hi", {31'd0, rh}, 32'd1);
    xfer(0, 1'b0, 32'h0000_0000, 3'd2, 32'h0000_0000, rd, nw, rl, rh);
    check_vec("oor_word0", rd, 32'h0102_0304);
`else
    check_vec("oor_waits", nw, 32'd0);
    check_vec("oor_resp_hi", {31'd0, rh}, 32'd0);
    xfer(0, 1'b0, 32'h0000_0000, 3'd2, 32'h0000_0000, rd, nw, rl, rh);
    check_vec("oor_word0", rd, 32'h0102_0355);
`endif

    // Misaligned halfword read at 0x21.
    xfer(0, 1'b0, 32'h0000_0021, 3'd1, 32'h0000_0000, rd, nw, rl, rh);
`ifdef AHB_RAM_ERROR_RESP_EN
    check_vec("mis_waits", nw, 32'd1);
    check_vec("mis_resp_low", {31'd0, rl}, 32'd1);
    check_vec("mis_resp_hi", {31'd0, rh}, 32'd1);
    check_vec("mis_rdata", rd, 32'h0000_0000);
`else
    check_vec("mis_waits", nw, 32'd0);
    check_vec("mis_resp_hi", {31'd0, rh}, 32'd0);
    check_vec("mis_rdata", rd, 32'h11AA_BBCC);
`endif

    // Reset during the second wait cycle of a write discards it.
    haddr = 32'h0000_0040; hsize = 3'd2; hwrite = 1'b1; htrans = 2'b10; hsel3 = 1'b1;
    @(posedge clk); #1;
    htrans = 2'b00; hsel3 = 1'b0; hwdata = 32'h1234_5678;
    check_vec("rstw_wait1_ready", {31'd0, hready3}, 32'd0);
    check_vec("rstw_wait1_rdata", hrdata3, 32'h0000_0000);
    @(posedge clk); #1;
    check_vec("rstw_wait2_ready", {31'd0, hready3}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_vec("rstw_ready", {31'd0, hready3}, 32'd1);
    check_vec("rstw_resp", {31'd0, hresp3}, 32'd0);
    check_vec("rstw_rdata", hrdata3, 32'h0000_0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(3, 1'b0, 32'h0000_0040, 3'd2, 32'h0000_0000, rd, nw, rl, rh);
    check_vec("rstw_kept", rd, 32'hCAFE_F00D);
    check_vec("rstw_rd_waits", nw, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_lite_ram_slave.md
# ahb_lite_ram_slave

AHB-Lite responder backed by on-chip RAM, with a programmable number of wait states and byte-lane writes. It sits on the same bus as `ahb_lite_rw_master`, in place of or beside `ahb_lite_sdram`. It serves as a known-good target: when the master reports errors against SDRAM, the same test run against this block separates master faults from SDRAM controller faults. It is synthesizable for the FPGA board top and usable as a simulation slave model.

## Interface

**Parameters**
- `ADDR_BITS`, default 10: word-address width. RAM depth is 2^ADDR_BITS × 32 bits (4 KiB at the default).
- `WAIT_STATES`, default 1, range 0–15: number of HREADY-low cycles inserted in every OKAY data phase.

**Ports** (clock and reset are single; reset is asynchronous, active-low)
- `HCLK` in 1: bus clock. All logic is on the rising edge.
- `HRESETn` in 1: asynchronous active-low reset.
- `HADDR` in 32: byte address.
- `HBURST` in 3: burst type. Ignored; every beat is addressed from `HADDR`.
- `HSEL` in 1: slave select.
- `HSIZE` in 3: 0 = byte, 1 = halfword, 2 = word. Values >2 are treated as word.
- `HTRANS` in 2: transfer type. A transfer exists only when `HTRANS[1]` = 1 (NONSEQ or SEQ).
- `HWDATA` in 32: write data, valid in the data phase.
- `HWRITE` in 1: 1 = write.
- `HRDATA` out 32: read data.
- `HREADY` out 1: data phase complete. This is also the bus-wide ready sampled by this block.
- `HRESP` out 1: 0 = OKAY, 1 = ERROR.

## Operation

**Address phase**
- A transfer is accepted at a rising edge where `HREADY`=1, `HSEL`=1 and `HTRANS[1]`=1.
- On acceptance, register the word address (`HADDR[ADDR_BITS+1:2]`), byte offset, size, write flag and error flag.
- IDLE or BUSY transfers, or `HSEL`=0, get no data phase; outputs stay OKAY with `HREADY`=1.

**Byte enables** (little-endian)
- Byte: lane `HADDR[1:0]`.
- Halfword: lanes {1,0} when `HADDR[1]`=0, lanes {3,2} when `HADDR[1]`=1.
- Word: all four lanes.

**Error conditions** (only with the macro below)
- Out of range: `HADDR[31:ADDR_BITS+2]` ≠ 0.
- Misaligned: halfword with `HADDR[0]`=1, or word with `HADDR[1:0]` ≠ 0.

**State machine**
- IDLE: no data phase pending. `HREADY`=1, `HRESP`=0.
  - OKAY transfer accepted → WAIT if `WAIT_STATES`>0, else DATA.
  - Error transfer accepted → ERR1.
- WAIT: `HREADY`=0, `HRESP`=0. Counter loaded with `WAIT_STATES`, decrements each cycle; moves to DATA when it reaches 1.
- DATA: `HREADY`=1, `HRESP`=0.
  - Write: the enabled bytes of `HWDATA` are written at the edge that ends DATA.
  - Read: `HRDATA` = `mem[addr_q]` during DATA.
  - A new transfer accepted at the same edge selects the next state exactly as from IDLE; otherwise → IDLE.
- ERR1: `HREADY`=0, `HRESP`=1 → ERR2. No wait states are applied.
- ERR2: `HREADY`=1, `HRESP`=1. Any new transfer is accepted as from IDLE.

**RAM behaviour**
- No RAM write on an error, IDLE or BUSY transfer.
- Reads ignore byte enables and return the full word.
- `HRDATA` = 0 in every cycle that is not a read DATA cycle.
- RAM contents are not reset.

## Timing

- Reset values: `HREADY`=1, `HRESP`=0, `HRDATA`=0, state IDLE, wait counter 0.
- Reset asserted mid-transfer: immediate return to IDLE; any pending write is discarded.
- OKAY latency: the data phase lasts `WAIT_STATES`+1 cycles after the address-phase edge.
- `WAIT_STATES`=0: back-to-back pipelined transfers complete one per cycle with `HREADY` held at 1.
- Read-after-write: a read in the data phase immediately after a write to the same word returns the new data. The read path is asynchronous from the registered address, so no forwarding logic is needed.
- `HRDATA` is combinational from registered state and RAM only. It has no combinational path from bus inputs.

## Configuration

- `AHB_RAM_ERROR_RESP_EN` defined:
  - Out-of-range and misaligned transfers receive the two-cycle ERROR response (ERR1, ERR2).
  - No write is performed for them.
- `AHB_RAM_ERROR_RESP_EN` not defined:
  - ERR1 and ERR2 are not compiled in, and `HRESP` is tied to 0.
  - Out-of-range addresses alias: upper bits are ignored.
  - Misaligned accesses use the lanes implied by `HADDR[1:0]` for bytes. For halfword, `HADDR[0]` is ignored; for word, `HADDR[1:0]` are ignored.

## Test plan

- `WAIT_STATES`=0, word write 0xDEADBEEF to address 0x10, then read 0x10 back-to-back → `HRDATA`=0xDEADBEEF in the read data phase; `HREADY` never low.
- `WAIT_STATES`=3, single read → `HREADY` low for exactly 3 cycles, then high with valid data; `HRESP`=0 throughout.
- Word 0x11223344 at 0x20, then byte write 0xAA at 0x22, then halfword 0xBBCC at 0x20 → word read returns 0x11AABBCC.
- Macro on, `ADDR_BITS`=10, write 0x55 to 0x1000 → `HREADY`=0/`HRESP`=1, then `HREADY`=1/`HRESP`=1; a following read of 0x0000 shows it unchanged.
- Macro on, halfword read at 0x21 → two-cycle ERROR. Macro off, same access → OKAY with lanes {1,0} of word 0x20.
- Assert `HRESETn` in the 2nd wait cycle of a write → `HREADY`=1, `HRESP`=0, `HRDATA`=0 immediately; the target word keeps its old value.
